// File: rtl/dct_job_scheduler.sv
// -----------------------------------------------------------------------------
// dct_job_scheduler
//
// Dispatch scheduler for the DCT mesh. It sits behind the PCIe-facing PE at
// mesh node (0,0) and shares the X*Y-1 blockDCT PEs between incoming jobs.
// Each accepted PCIe word becomes one NoC packet addressed to a free PE. The
// PE is chosen round-robin, starting just after the most recently used index.
// A busy bitmap allows only one outstanding job per PE. Returning result
// packets free their PE and are forwarded as raw data to the PCIe output.
//
// Packet layout, LSB first:
//   data [data_width-1:0] | x [x_size] | y [y_size] | pck [pck_num] (MSBs)
// PE index = x + X*y. Index 0 (the PCIe node itself) is never scheduled.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   i_valid_pci/i_data_pci         PCIe job in
//   o_ready_pci                    job accepted when high with i_valid_pci
//   o_valid_pci/o_data_pci         result out to PCIe
//   i_ready_pci                    PCIe sink ready
//   o_valid_noc/o_data_noc         job packet to the mesh
//   i_ready_noc                    mesh accepts the packet
//   i_valid_noc/i_data_noc         result packet from the mesh
//   o_ready_noc                    result packet accepted
//   busy_map                       bit i set = PE i has a job outstanding
//
// Optional feature macro: SCHED_STATS_EN
//   When defined, adds the 32-bit wrapping counters jobs_sent, jobs_done and
//   stall_cycles.
// -----------------------------------------------------------------------------
module dct_job_scheduler #(
  parameter int X           = 8,
  parameter int Y           = 8,
  parameter int pck_num     = 12,
  parameter int data_width  = 256,
  parameter int x_size      = $clog2(X),
  parameter int y_size      = $clog2(Y),
  parameter int total_width = x_size + y_size + pck_num + data_width
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_valid_pci,
  input  logic [data_width-1:0]  i_data_pci,
  output logic                   o_ready_pci,
  output logic                   o_valid_pci,
  output logic [data_width-1:0]  o_data_pci,
  input  logic                   i_ready_pci,
  output logic                   o_valid_noc,
  output logic [total_width-1:0] o_data_noc,
  input  logic                   i_ready_noc,
  input  logic                   i_valid_noc,
  input  logic [total_width-1:0] i_data_noc,
  output logic                   o_ready_noc,
  output logic [X*Y-1:0]         busy_map
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]            jobs_sent,
  output logic [31:0]            jobs_done,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int N     = X * Y;
  localparam int IDX_W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // First free index strictly after ptr, searching upward and wrapping from
  // N-1 back to 1 (index 0 is skipped). Only called when some PE is free.
  function automatic logic [IDX_W-1:0] next_free(input logic [N-1:0]     busy,
                                                 input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               c;
    sel   = '0;
    found = 1'b0;
    for (int off = 1; off < N; off++) begin
      c = int'(ptr) + off;
      c = (c >= N) ? (c - (N - 1)) : c;
      if (!found && !busy[c]) begin
        sel   = IDX_W'(c);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Registers
  state_t                 state_r;
  logic                   ready_r;
  logic                   valid_noc_r;
  logic [total_width-1:0] data_noc_r;
  logic                   valid_pci_r;
  logic [data_width-1:0]  data_pci_r;
  logic [N-1:0]           busy_r;
  logic [pck_num-1:0]     pck_cnt_r;
  logic [IDX_W-1:0]       rr_ptr_r;

  // Combinational
  state_t                 state_next_s;
  logic                   pci_hs_s;
  logic                   noc_hs_s;
  logic                   ret_hs_s;
  logic                   ret_ready_s;
  logic [IDX_W-1:0]       sel_s;
  logic [x_size-1:0]      sel_x_s;
  logic [y_size-1:0]      sel_y_s;
  logic [x_size-1:0]      ret_x_s;
  logic [y_size-1:0]      ret_y_s;
  int                     ret_idx_s;
  logic [N-1:0]           set_mask_s;
  logic [N-1:0]           clr_mask_s;
  logic [N-1:0]           busy_next_s;
  logic                   ready_next_s;
  logic                   ret_pck_unused_s;

  // Handshakes. ready_r is only ever high in IDLE; the state term keeps the
  // dispatch handshake tied to IDLE regardless.
  assign pci_hs_s    = i_valid_pci && ready_r && (state_r == IDLE);
  assign noc_hs_s    = (state_r == SEND) && i_ready_noc;
  assign ret_ready_s = !valid_pci_r || i_ready_pci;
  assign ret_hs_s    = i_valid_noc && ret_ready_s;

  // Round-robin choice and its mesh coordinates
  assign sel_s   = next_free(busy_r, rr_ptr_r);
  assign sel_x_s = x_size'(int'(sel_s) % X);
  assign sel_y_s = y_size'(int'(sel_s) / X);

  // Header of the returning packet; the packet number is not needed here
  assign ret_x_s          = i_data_noc[data_width +: x_size];
  assign ret_y_s          = i_data_noc[data_width + x_size +: y_size];
  assign ret_pck_unused_s = ^i_data_noc[total_width-1 -: pck_num];

  // Busy bitmap update: set for the new job, clear for the returning PE
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    ret_idx_s  = int'(ret_x_s) + X * int'(ret_y_s);
    if (pci_hs_s) begin
      set_mask_s[sel_s] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    // Returns from index 0 or out-of-range headers are forwarded but touch
    // no busy bit.
    if (ret_hs_s && (ret_idx_s > 0) && (ret_idx_s < N)) begin
      clr_mask_s[ret_idx_s] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    busy_next_s    = (busy_r & ~clr_mask_s) | set_mask_s;
    busy_next_s[0] = 1'b0;
  end

  // Dispatch FSM next state and the registered-ready look-ahead
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pci_hs_s) begin
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (i_ready_noc) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    // Ready is registered, so compute it from next-cycle state and bitmap;
    // a freed PE then shows on o_ready_pci the cycle after its return.
    ready_next_s = (state_next_s == IDLE) && !(&busy_next_s[N-1:1]);
  end

  // Dispatch state, packet register, round-robin pointer and packet counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      ready_r     <= 1'b0;
      valid_noc_r <= 1'b0;
      data_noc_r  <= '0;
      busy_r      <= '0;
      pck_cnt_r   <= '0;
      rr_ptr_r    <= '0;
    end else begin
      state_r     <= state_next_s;
      ready_r     <= ready_next_s;
      valid_noc_r <= (state_next_s == SEND);
      busy_r      <= busy_next_s;
      if (pci_hs_s) begin
        data_noc_r <= {pck_cnt_r, sel_y_s, sel_x_s, i_data_pci};
        rr_ptr_r   <= sel_s;
      end
      if (noc_hs_s) begin
        pck_cnt_r <= pck_cnt_r + pck_num'(1);
      end
    end
  end

  // One-entry result register towards PCIe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_pci_r <= 1'b0;
      data_pci_r  <= '0;
    end else begin
      if (ret_hs_s) begin
        valid_pci_r <= 1'b1;
        data_pci_r  <= i_data_noc[data_width-1:0];
      end else if (i_ready_pci) begin
        valid_pci_r <= 1'b0;
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] jobs_sent_r;
  logic [31:0] jobs_done_r;
  logic [31:0] stall_cycles_r;

  // Wrapping statistics counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      jobs_sent_r    <= 32'd0;
      jobs_done_r    <= 32'd0;
      stall_cycles_r <= 32'd0;
    end else begin
      if (noc_hs_s) begin
        jobs_sent_r <= jobs_sent_r + 32'd1;
      end
      if (ret_hs_s) begin
        jobs_done_r <= jobs_done_r + 32'd1;
      end
      if (i_valid_pci && !ready_r) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
    end
  end

  assign jobs_sent    = jobs_sent_r;
  assign jobs_done    = jobs_done_r;
  assign stall_cycles = stall_cycles_r;
`endif

  assign o_ready_pci = ready_r;
  assign o_valid_noc = valid_noc_r;
  assign o_data_noc  = data_noc_r;
  assign o_valid_pci = valid_pci_r;
  assign o_data_pci  = data_pci_r;
  assign o_ready_noc = ret_ready_s;
  assign busy_map    = busy_r;

endmodule
